uart_echo_responder: RTL and testbench
======================================

// Module: uart_echo_responder
// PURPOSE
//  Far-end consumer of UART_Rx output and producer of UART_Tx input. Captures each received
//  byte into a small FIFO and re-issues it to the transmitter under the Tx enable/busy
//  handshake, forming a buffered echo path. Sits between the Rx and Tx instances of a UART top.
// PARAMETERS
//  PAYLOAD_BITS  8   data width; must match UART_Rx/UART_Tx
//  FIFO_DEPTH    4   FIFO entries; power of 2, >=2
// PORTS
//  clk          in   1                     single clock; all logic on rising edge
//  rst          in   1                     asynchronous, active-low reset
//  rx_data      in   PAYLOAD_BITS          byte from UART_Rx
//  rx_valid     in   1                     UART_Rx valid strobe
//  rx_break     in   1                     UART_Rx break indication
//  tx_busy      in   1                     UART_Tx busy
//  echo_en      in   1                     1 = accept and echo bytes; 0 = drain only, no capture
//  clr_status   in   1                     1-cycle pulse clears sticky flags
//  tx_en        out  1                     UART_Tx enable
//  tx_data      out  PAYLOAD_BITS          byte to UART_Tx
//  fifo_level   out  $clog2(FIFO_DEPTH)+1  occupied entries
//  overflow     out  1                     sticky: byte dropped on full FIFO
//  break_seen   out  1                     sticky: rx_break observed
// BEHAVIOUR
//  Reset (rst=0, async): tx_en=0, tx_data=0, fifo_level=0, overflow=0, break_seen=0, state IDLE.
//  Capture: push on rising edge of rx_valid (registered edge detect) when echo_en=1 and
//   rx_break=0; byte written the cycle after the edge. Held-high rx_valid => one push.
//  rx_break=1 any cycle: no push; break_seen<=1. Sticky flags cleared by clr_status; a
//   set event in the same cycle as clr_status wins (flag stays 1).
//  Full: push dropped, overflow<=1, FIFO unchanged. Push+pop same cycle while full: both
//   happen, level unchanged, no overflow. Push+pop while empty impossible (pop needs data).
//  Pointers wrap modulo FIFO_DEPTH; level = wr_count - rd_count in $clog2+1 bits.
//  Tx FSM:
//   IDLE:      if level!=0 && tx_busy==0 -> pop head into tx_data, tx_en<=1, go LAUNCH.
//   LAUNCH:    hold tx_en=1 until tx_busy==1 sampled; then tx_en<=0, go WAIT_DONE.
//   WAIT_DONE: wait tx_busy==0 -> IDLE. Back-to-back bytes: >=1 idle cycle between frames.
//  tx_data stable from pop until return to IDLE. Latency rx_valid edge -> tx_en (empty FIFO,
//   Tx idle) = 3 clk.
//  echo_en=0 mid-operation: no new pushes; queued bytes still drain; active frame completes.
//  Reset mid-frame: FIFO discarded, tx_en drops immediately (async).
// CONFIGURATION
//  UART_ECHO_CASE_SWAP_EN defined: bytes in 8'h61..8'h7A converted to 8'h41..8'h5A at push
//   (requires PAYLOAD_BITS==8; elaboration error otherwise). Undefined: bytes echoed verbatim.
// STRUCTURE
//  Package uart_pkg: state enum {IDLE,LAUNCH,WAIT_DONE}, ASCII case constants, level-width
//   function. Sub-module uart_echo_fifo (sync FIFO: push/pop/full/empty/level); FSM and flag
//   logic stay in this module.
// TESTING
//  Single byte 8'hA5, Tx idle -> tx_en at cycle 3, tx_data=8'hA5, tx_en drops after tx_busy=1.
//  Five bytes 01..05 with tx_busy held 1, DEPTH=4 -> level=4, overflow=1, echo 01..04 in order.
//  Full FIFO + push 8'h10 same cycle as pop -> level stays 4, overflow stays 0, 10 echoed last.
//  rx_break=1 with rx_valid edge -> no push, break_seen=1; clr_status -> break_seen=0.
//  rst=0 during LAUNCH with level=2 -> tx_en=0 at once, level=0, flags 0; no stale echo after.
//  CASE_SWAP_EN: push 8'h61, 8'h7B -> echo 8'h41, 8'h7B; undefined: echo 8'h61, 8'h7B.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo responder.
// UART_ECHO_CASE_SWAP_EN enables upper-casing of ASCII lowercase bytes at capture.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_t;

  localparam logic [7:0] ASCII_LC_A     = 8'h61;
  localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

  // Level counter needs one extra bit so that full and empty are distinguishable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    if (b >= ASCII_LC_A && b <= ASCII_LC_Z) return b - ASCII_CASE_OFS;
    return b;
  endfunction

endpackage

// File: rtl/uart_echo_fifo.sv
// Synchronous FIFO with free-running wrap counters; level = wr_cnt - rd_cnt.
module uart_echo_fifo
  import uart_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [W-1:0]              push_data,
  input  logic                      pop,
  output logic [W-1:0]              head,
  output logic                      full,
  output logic                      empty,
  output logic [lvl_w(DEPTH)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [LW-1:0] wr_cnt, rd_cnt;
  logic          do_push, do_pop;

  assign level = wr_cnt - rd_cnt;
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign head  = mem[rd_cnt[AW-1:0]];

  // A pop frees a slot in the same cycle, so push into a full FIFO is allowed then.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (do_push) wr_cnt <= wr_cnt + 1'b1;
      if (do_pop)  rd_cnt <= rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_cnt[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_echo_responder.sv
// Buffered echo path between UART_Rx and UART_Tx: captures bytes into a FIFO and replays them.
// Optional UART_ECHO_CASE_SWAP_EN upper-cases 'a'..'z' at capture (8-bit payload only).
module uart_echo_responder
  import uart_pkg::*;
#(
  parameter int PAYLOAD_BITS = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PAYLOAD_BITS-1:0]          rx_data,
  input  logic                             rx_valid,
  input  logic                             rx_break,
  input  logic                             tx_busy,
  input  logic                             echo_en,
  input  logic                             clr_status,
  output logic                             tx_en,
  output logic [PAYLOAD_BITS-1:0]          tx_data,
  output logic [lvl_w(FIFO_DEPTH)-1:0]     fifo_level,
  output logic                             overflow,
  output logic                             break_seen
);
  localparam int LW = lvl_w(FIFO_DEPTH);

  tx_state_t                 state, state_nxt;
  logic                      rx_valid_q, rx_edge;
  logic                      push_q;
  logic [PAYLOAD_BITS-1:0]   push_data_q, cap_data;
  logic                      pop, full, empty;
  logic [PAYLOAD_BITS-1:0]   head;
  logic                      tx_en_nxt;
  logic [PAYLOAD_BITS-1:0]   tx_data_nxt;
  logic [LW-1:0]             level;

`ifdef UART_ECHO_CASE_SWAP_EN
  if (PAYLOAD_BITS != 8) begin : g_bad_width
    $error("UART_ECHO_CASE_SWAP_EN requires PAYLOAD_BITS == 8");
  end
  assign cap_data = to_upper(rx_data);
`else
  assign cap_data = rx_data;
`endif

  assign rx_edge    = rx_valid && !rx_valid_q;
  assign fifo_level = level;

  // Capture is staged one cycle so the FIFO write lands the cycle after the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_valid_q  <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      overflow    <= 1'b0;
      break_seen  <= 1'b0;
    end else begin
      rx_valid_q  <= rx_valid;
      push_q      <= rx_edge && echo_en && !rx_break;
      push_data_q <= cap_data;
      if (rx_break)        break_seen <= 1'b1;
      else if (clr_status) break_seen <= 1'b0;
      if (push_q && full && !pop) overflow <= 1'b1;
      else if (clr_status)        overflow <= 1'b0;
    end
  end

  uart_echo_fifo #(.W(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tx_en   <= 1'b0;
      tx_data <= '0;
    end else begin
      state   <= state_nxt;
      tx_en   <= tx_en_nxt;
      tx_data <= tx_data_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    tx_en_nxt   = tx_en;
    tx_data_nxt = tx_data;
    unique case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop         = 1'b1;
          tx_data_nxt = head;
          tx_en_nxt   = 1'b1;
          state_nxt   = LAUNCH;
        end
      end
      LAUNCH: begin
        if (tx_busy) begin
          tx_en_nxt = 1'b0;
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: begin
        tx_en_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_echo_responder.sv
// Directed bench for uart_echo_responder; expected values are hand-derived constants.
module tb_uart_echo_responder;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid, rx_break, tx_busy, echo_en, clr_status;
  logic       tx_en;
  logic [7:0] tx_data;
  logic [2:0] fifo_level;
  logic       overflow, break_seen;

  int total = 0;
  int bad   = 0;

  uart_echo_responder #(.PAYLOAD_BITS(8), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_break   (rx_break),
    .tx_busy    (tx_busy),
    .echo_en    (echo_en),
    .clr_status (clr_status),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .break_seen (break_seen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  // Let the FSM launch, check the byte, then play out one Tx frame.
  task automatic echo_one(input logic [7:0] exp, input string tag);
    int n = 0;
    tx_busy = 1'b0;
    while (!tx_en && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_launch"}, tx_en, 1);
    chk(tag, tx_data, exp);
    tx_busy = 1'b1;
    tick();
    chk({tag, "_drop"}, tx_en, 0);
    tx_busy = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; rx_data = '0; rx_valid = 0; rx_break = 0;
    tx_busy = 0; echo_en = 1; clr_status = 0;
    tick(); tick();
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_brk", break_seen, 0);
    #3 rst = 1'b1;
    tick();

    // Single byte: tx_en rises 3 clocks after the rx_valid edge.
    rx_data = 8'hA5; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("lat_c1", tx_en, 0);
    tick();
    chk("lat_c2", tx_en, 0);
    chk("lat_c2_lvl", fifo_level, 1);
    tick();
    chk("lat_c3", tx_en, 1);
    chk("lat_data", tx_data, 8'hA5);
    chk("lat_lvl", fifo_level, 0);
    tick();
    chk("launch_hold", tx_en, 1);
    tx_busy = 1'b1;
    tick();
    chk("launch_drop", tx_en, 0);
    chk("data_stable", tx_data, 8'hA5);
    tx_busy = 1'b0;
    tick();

    // Overflow: five bytes into a depth-4 FIFO with Tx busy.
    tx_busy = 1'b1;
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overflow, 1);
    for (int i = 1; i <= 4; i++) echo_one(8'(i), $sformatf("ovf_echo%0d", i));
    chk("ovf_empty", fifo_level, 0);
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Push and pop on the same cycle while full.
    tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(8'h20 + 8'(i));
    chk("pp_full", fifo_level, 4);
    rx_data = 8'h10; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; tx_busy = 1'b0;
    tick();
    chk("pp_level", fifo_level, 4);
    chk("pp_ovf", overflow, 0);
    chk("pp_en", tx_en, 1);
    chk("pp_data", tx_data, 8'h20);
    tx_busy = 1'b1; tick(); tx_busy = 1'b0; tick();
    echo_one(8'h21, "pp_e21");
    echo_one(8'h22, "pp_e22");
    echo_one(8'h23, "pp_e23");
    echo_one(8'h10, "pp_e10");
    chk("pp_ovf_end", overflow, 0);

    // Break: no capture, sticky flag; set wins over clear.
    rx_data = 8'h77; rx_valid = 1'b1; rx_break = 1'b1;
    tick();
    rx_valid = 1'b0; rx_break = 1'b0;
    tick(); tick(); tick();
    chk("brk_level", fifo_level, 0);
    chk("brk_en", tx_en, 0);
    chk("brk_flag", break_seen, 1);
    rx_break = 1'b1; clr_status = 1'b1; tick();
    rx_break = 1'b0;
    chk("brk_set_wins", break_seen, 1);
    tick(); clr_status = 1'b0;
    chk("brk_clr", break_seen, 0);

    // echo_en low: no capture.
    echo_en = 1'b0;
    push_byte(8'h55);
    tick();
    chk("noecho_level", fifo_level, 0);
    chk("noecho_en", tx_en, 0);
    echo_en = 1'b1;

    // Case handling at capture.
    tx_busy = 1'b1;
    push_byte(8'h61);
    push_byte(8'h7B);
`ifdef UART_ECHO_CASE_SWAP_EN
    echo_one(8'h41, "case_61");
`else
    echo_one(8'h61, "case_61");
`endif
    echo_one(8'h7B, "case_7b");

    // Async reset while launching with two bytes still queued.
    rx_break = 1'b1; tick(); rx_break = 1'b0;
    tx_busy = 1'b1;
    push_byte(8'h31); push_byte(8'h32); push_byte(8'h33);
    tx_busy = 1'b0;
    tick();
    chk("mr_launch", tx_en, 1);
    chk("mr_level2", fifo_level, 2);
    rst = 1'b0;
    #1;
    chk("mr_tx_en", tx_en, 0);
    chk("mr_level", fifo_level, 0);
    chk("mr_brk", break_seen, 0);
    chk("mr_ovf", overflow, 0);
    chk("mr_data", tx_data, 0);
    #3 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("mr_stale%0d", i), tx_en, 0);
    end
    chk("mr_level_end", fifo_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
